// File: rtl/ff_pkg.sv
// Shared definitions for the multimode flip-flop bank.
//   FF_MODE_W  : width of the runtime mode select
//   ff_mode_e  : JK / SR / D / T behaviour selector
package ff_pkg;

  localparam int FF_MODE_W = 2;

  typedef enum logic [FF_MODE_W-1:0] {
    FF_MODE_JK = 2'b00,
    FF_MODE_SR = 2'b01,
    FF_MODE_D  = 2'b10,
    FF_MODE_T  = 2'b11
  } ff_mode_e;

endpackage

// File: rtl/ff_next_bit.sv
// Combinational next-state logic for one flip-flop of the bank.
// Ports:
//   mode    : behaviour select (JK, SR, D, T)
//   j, k    : J/S/D/T and K/R inputs (k unused in D and T modes)
//   q       : current stored bit
//   q_next  : bit value to store on the next enabled edge
//   illegal : S=R=1 seen while in SR mode
module ff_next_bit
  import ff_pkg::*;
(
  input  logic [FF_MODE_W-1:0] mode,
  input  logic                 j,
  input  logic                 k,
  input  logic                 q,
  output logic                 q_next,
  output logic                 illegal
);

  always_comb begin
    q_next  = q;
    illegal = 1'b0;
    case (ff_mode_e'(mode))
      FF_MODE_JK: begin
        case ({j, k})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          2'b11:   q_next = ~q;
          default: q_next = q;
        endcase
      end
      FF_MODE_SR: begin
        case ({j, k})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          // S=R=1 keeps the bit and only raises the error flag
          2'b11:   illegal = 1'b1;
          default: q_next = q;
        endcase
      end
      FF_MODE_D: q_next = j;
      FF_MODE_T: q_next = j ? ~q : q;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops with runtime-selectable JK/SR/D/T behaviour,
// sticky SR-illegal flags and a saturating count of word changes.
// Ports:
//   clk, rst  : rising-edge clock, async active-high reset
//   en        : update enable (clr_err still acts when low)
//   mode      : 00=JK 01=SR 10=D 11=T
//   j, k      : per-bit inputs
//   clr_err   : clears err_mask (a new illegal input in the same cycle wins)
//   q, qn     : stored word and its complement
//   err_mask  : sticky per-bit SR illegal flags; sr_err is their OR
//   changed   : q changed on the last edge
//   chg_cnt   : saturating count of changed pulses
module multimode_ff_bank
  import ff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [FF_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]     j,
  input  logic [WIDTH-1:0]     k,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qn,
  output logic [WIDTH-1:0]     err_mask,
  output logic                 sr_err,
  output logic                 changed,
  output logic [CNT_W-1:0]     chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal;
  logic [WIDTH-1:0] err_base;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    ff_next_bit u_next (
      .mode    (mode),
      .j       (j[gi]),
      .k       (k[gi]),
      .q       (q[gi]),
      .q_next  (q_next[gi]),
      .illegal (illegal[gi])
    );
  end

  // clr_err applies first so a simultaneous new error survives the clear
  assign err_base = clr_err ? '0 : err_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= RESET_VAL;
      err_mask <= '0;
      changed  <= 1'b0;
      chg_cnt  <= '0;
    end else begin
      if (en) begin
        q        <= q_next;
        err_mask <= err_base | illegal;
        changed  <= (q_next != q);
        if (changed && (chg_cnt != CNT_MAX)) begin
          chg_cnt <= chg_cnt + 1'b1;
        end
      end else begin
        err_mask <= err_base;
        changed  <= 1'b0;
      end
    end
  end

  assign qn     = ~q;
  assign sr_err = |err_mask;

endmodule

// File: tb/tb_multimode_ff_bank.sv
module tb_multimode_ff_bank;
  import ff_pkg::*;

  localparam int         WIDTH = 4;
  localparam int         CNT_W = 2;
  localparam logic [3:0] RVAL  = 4'b1010;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] j = '0;
  logic [WIDTH-1:0] k = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] q, qn, err_mask;
  logic             sr_err, changed;
  logic [CNT_W-1:0] chg_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  multimode_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VAL(RVAL)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .j        (j),
    .k        (k),
    .clr_err  (clr_err),
    .q        (q),
    .qn       (qn),
    .err_mask (err_mask),
    .sr_err   (sr_err),
    .changed  (changed),
    .chg_cnt  (chg_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] jj,
                       input logic [3:0] kk, input logic c);
    en = e; mode = m; j = jj; k = kk; clr_err = c;
  endtask

  initial begin
    #3 rst = 1'b1;
    #1;
    check("rst_q", q, RVAL);
    check("rst_qn", qn, 4'b0101);
    check("rst_err", err_mask, 0);
    check("rst_srerr", sr_err, 0);
    check("rst_cnt", chg_cnt, 0);
    check("rst_changed", changed, 0);
    step();
    check("rst_hold_q", q, RVAL);
    #4 rst = 1'b0;

    drive(1, FF_MODE_D, 4'b0000, 4'b0000, 0);
    step();
    check("d_zero_q", q, 4'b0000);
    check("d_zero_chg", changed, 1);

    drive(1, FF_MODE_JK, 4'b1111, 4'b0000, 0);
    step();
    check("jk_set_q", q, 4'b1111);
    check("jk_set_cnt", chg_cnt, 1);

    drive(1, FF_MODE_JK, 4'b1111, 4'b1111, 0);
    step();
    check("jk_tog_q", q, 4'b0000);
    check("jk_tog_cnt", chg_cnt, 2);

    drive(1, FF_MODE_JK, 4'b0000, 4'b0000, 0);
    step();
    check("jk_hold_q", q, 4'b0000);
    check("jk_hold_chg", changed, 0);
    check("jk_hold_cnt", chg_cnt, 3);

    drive(1, FF_MODE_SR, 4'b0011, 4'b0101, 0);
    step();
    check("sr_q", q, 4'b0010);
    check("sr_err_mask", err_mask, 4'b0001);
    check("sr_srerr", sr_err, 1);
    check("sr_cnt_sat", chg_cnt, 3);

    drive(1, FF_MODE_SR, 4'b0000, 4'b0000, 1);
    step();
    check("clr_err_mask", err_mask, 4'b0000);
    check("clr_srerr", sr_err, 0);
    check("clr_q", q, 4'b0010);

    drive(1, FF_MODE_SR, 4'b0100, 4'b0100, 1);
    step();
    check("clr_new_err", err_mask, 4'b0100);
    check("clr_new_q", q, 4'b0010);

    drive(1, FF_MODE_D, 4'b0110, 4'b0000, 0);
    step();
    check("d_q", q, 4'b0110);
    check("d_err_sticky", err_mask, 4'b0100);

    drive(1, FF_MODE_T, 4'b0011, 4'b0000, 0);
    step();
    check("t_q", q, 4'b0101);
    check("t_qn", qn, 4'b1010);

    drive(0, FF_MODE_T, 4'b1111, 4'b0000, 0);
    step();
    check("en0_q", q, 4'b0101);
    check("en0_chg", changed, 0);
    check("en0_err", err_mask, 4'b0100);

    drive(0, FF_MODE_SR, 4'b1111, 4'b1111, 1);
    step();
    check("en0_clr_err", err_mask, 4'b0000);
    check("en0_clr_q", q, 4'b0101);

    // saturation run from a fresh reset
    drive(1, FF_MODE_T, 4'b0001, 4'b0000, 0);
    #2 rst = 1'b1;
    #1 check("rst2_q", q, RVAL);
    check("rst2_cnt", chg_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("sat_q1", q, 4'b1011);
    check("sat_cnt0", chg_cnt, 0);
    begin
      logic [1:0] exp_cnt [5];
      exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
      exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
      for (int i = 0; i < 5; i++) begin
        step();
        check($sformatf("sat_cnt_%0d", i), chg_cnt, exp_cnt[i]);
        check($sformatf("sat_q_%0d", i), q, (i % 2 == 0) ? 4'b1010 : 4'b1011);
      end
    end

    // async reset between edges while still toggling
    #3 rst = 1'b1;
    #1;
    check("arst_q", q, RVAL);
    check("arst_qn", qn, 4'b0101);
    check("arst_cnt", chg_cnt, 0);
    check("arst_chg", changed, 0);
    check("arst_err", err_mask, 0);
    step();
    check("arst_hold_q", q, RVAL);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_q", q, 4'b1011);
    check("post_chg", changed, 1);
    check("post_cnt", chg_cnt, 0);
    step();
    check("post2_q", q, 4'b1010);
    check("post2_cnt", chg_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
